// File: rtl/injection_campaign_ctrl_pkg.sv
// Shared definitions for the fault-injection campaign controller:
// FSM encodings, fault-site codes, LFSR taps and the site-to-mask helper.
package injection_campaign_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_APPLY  = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_CHECK  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        SITE_A    = 3'd0,
        SITE_B    = 3'd1,
        SITE_C    = 3'd2,
        SITE_D    = 3'd3,
        SITE_E    = 3'd4,
        SITE_F    = 3'd5,
        SITE_NONE = 3'd7
    } site_e;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (register bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Codes 6 and 7 both select a golden (unfaulted) run
    function automatic logic [5:0] site_mask(input logic [2:0] site);
        logic [5:0] m;
        m = '0;
        if (site < 3'd6)
            m = 6'b00_0001 << site;
        return m;
    endfunction

endpackage

// File: rtl/injection_campaign_ctrl_if.sv
// Campaign control and DUT-observation signals of the injection controller.
interface injection_campaign_ctrl_if;

    logic       start;
    logic [7:0] num_vectors;
    logic [2:0] fault_site;
    logic [5:0] stim;
    logic       inj_en;
    logic [1:0] dut_y;
    logic [1:0] gold_y;
    logic       busy;
    logic       done;
    logic [7:0] err_cnt;
    logic [7:0] vec_idx;

    modport master (
        output start, num_vectors, fault_site, dut_y, gold_y,
        input  stim, inj_en, busy, done, err_cnt, vec_idx
    );

    modport slave (
        input  start, num_vectors, fault_site, dut_y, gold_y,
        output stim, inj_en, busy, done, err_cnt, vec_idx
    );

endinterface

// File: rtl/injection_campaign_ctrl_lfsr.sv
// 8-bit Fibonacci stimulus LFSR; advances only when step is high and
// reloads SEED solely on reset.
module inj_lfsr8
    import injection_campaign_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (step)
            q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            q_q <= SEED;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/injection_campaign_ctrl.sv
// Fault-injection campaign sequencer: drives LFSR vectors (optionally with one
// flipped bit) to a DUT, waits to settle, and counts output mismatches.
module injection_campaign_ctrl
    import injection_campaign_ctrl_pkg::*;
#(
    parameter logic [7:0]  SEED       = 8'hA5,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    injection_campaign_ctrl_if.slave    ctl
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] nvec_q,  nvec_d;
    logic [2:0] site_q,  site_d;
    logic [7:0] err_q,   err_d;
    logic [7:0] idx_q,   idx_d;
    logic [3:0] cnt_q,   cnt_d;

    logic [7:0] lfsr;
    logic       lfsr_step;
    logic       active;
    logic [5:0] mask;

    inj_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .step (lfsr_step),
        .q    (lfsr)
    );

    // LFSR moves once per vector, on the CHECK exit edge, so stim holds steady
    assign lfsr_step = (state_q == ST_CHECK);

    always_comb begin
        state_d = state_q;
        nvec_d  = nvec_q;
        site_d  = site_q;
        err_d   = err_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ctl.start) begin
                    state_d = ST_LOAD;
                    nvec_d  = ctl.num_vectors;
                    site_d  = ctl.fault_site;
                    err_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = (nvec_q == 8'd0) ? ST_DONE : ST_APPLY;
            end
            ST_APPLY: begin
                cnt_d   = SETTLE_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0)
                    state_d = ST_CHECK;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            ST_CHECK: begin
                if ((ctl.dut_y != ctl.gold_y) && (err_q != 8'hFF))
                    err_d = err_q + 8'd1;
                if (idx_q == nvec_q - 8'd1) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            nvec_q  <= '0;
            site_q  <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            nvec_q  <= nvec_d;
            site_q  <= site_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode directly from registers so reset clears them without a clock
    assign active      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                         (state_q == ST_CHECK);
    assign mask        = site_mask(site_q);
    assign ctl.stim    = active ? (lfsr[5:0] ^ mask) : '0;
    assign ctl.inj_en  = active && (mask != '0);
    assign ctl.busy    = (state_q != ST_IDLE);
    assign ctl.done    = (state_q == ST_DONE);
    assign ctl.err_cnt = err_q;
    assign ctl.vec_idx = idx_q;

endmodule

// File: tb/tb_injection_campaign_ctrl.sv
// Directed self-checking bench for injection_campaign_ctrl (SEED=A5, SETTLE_CYC=2).
module tb_injection_campaign_ctrl;

    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    logic [5:0] app_stim [0:15];

    int         done_at;
    int         unstable;
    int         inj_bad;
    int         zero_bad;
    logic [7:0] load_err;
    int         extra_done;

    injection_campaign_ctrl_if bus ();

    injection_campaign_ctrl #(
        .SEED       (8'hA5),
        .SETTLE_CYC (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .ctl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start, then walks the campaign cycle by cycle (cycle 1 = LOAD).
    // At cycle 'poke' a second start with altered site/length is attempted.
    task automatic run_camp(input logic [7:0] nv, input logic [2:0] fs, input int poke,
                            input int limit, output int d_at, output int unst,
                            output int ibad, output int zbad, output logic [7:0] lerr);
        logic exp_inj;
        int   p;
        int   v;
        exp_inj = (fs < 3'd6);
        d_at = -1;
        unst = 0;
        ibad = 0;
        zbad = 0;
        lerr = 8'hxx;
        bus.num_vectors = nv;
        bus.fault_site  = fs;
        bus.start       = 1'b1;
        tick();
        for (int c = 1; c <= limit; c++) begin
            if (c == poke) begin
                bus.start       = 1'b1;
                bus.fault_site  = 3'd7;
                bus.num_vectors = nv + 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                if (bus.stim !== 6'd0 || bus.inj_en !== 1'b0) zbad++;
                d_at = c;
                break;
            end
            if (c == 1) begin
                lerr = bus.err_cnt;
                if (bus.stim !== 6'd0 || bus.inj_en !== 1'b0) zbad++;
            end else begin
                p = (c - 2) % 4;
                v = (c - 2) / 4;
                if (p == 0) begin
                    if (v < 16) app_stim[v] = bus.stim;
                end else if (v < 16 && bus.stim !== app_stim[v]) begin
                    unst++;
                end
                if (bus.inj_en !== exp_inj) ibad++;
            end
            tick();
        end
        bus.start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.start       = 1'b0;
        bus.num_vectors = 8'd0;
        bus.fault_site  = 3'd7;
        bus.dut_y       = 2'b10;
        bus.gold_y      = 2'b10;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        check("rst_busy",   {31'd0, bus.busy},   32'd0);
        check("rst_done",   {31'd0, bus.done},   32'd0);
        check("rst_stim",   {26'd0, bus.stim},   32'd0);
        check("rst_inj",    {31'd0, bus.inj_en}, 32'd0);
        check("rst_err",    {24'd0, bus.err_cnt}, 32'd0);
        check("rst_idx",    {24'd0, bus.vec_idx}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        tick();

        // Golden run: LFSR A5,4A,95,2A
        run_camp(8'd4, 3'd7, -1, 40, done_at, unstable, inj_bad, zero_bad, load_err);
        check("gold_done_at", done_at, 32'd18);
        check("gold_stim0", {26'd0, app_stim[0]}, 32'h25);
        check("gold_stim1", {26'd0, app_stim[1]}, 32'h0A);
        check("gold_stim2", {26'd0, app_stim[2]}, 32'h15);
        check("gold_stim3", {26'd0, app_stim[3]}, 32'h2A);
        check("gold_inj",   inj_bad, 32'd0);
        check("gold_hold",  unstable, 32'd0);
        check("gold_zero",  zero_bad, 32'd0);
        check("gold_err",   {24'd0, bus.err_cnt}, 32'd0);
        tick();
        check("gold_pulse", {30'd0, bus.done, bus.busy}, 32'd0);
        check("gold_idx",   {24'd0, bus.vec_idx}, 32'd3);

        // Forced mismatch at bit c: LFSR 54,A9,53 with bit2 flipped
        bus.dut_y = 2'b01;
        run_camp(8'd3, 3'd2, -1, 40, done_at, unstable, inj_bad, zero_bad, load_err);
        check("mis_done_at", done_at, 32'd14);
        check("mis_stim0", {26'd0, app_stim[0]}, 32'h10);
        check("mis_stim1", {26'd0, app_stim[1]}, 32'h2D);
        check("mis_stim2", {26'd0, app_stim[2]}, 32'h17);
        check("mis_inj",   inj_bad, 32'd0);
        check("mis_hold",  unstable, 32'd0);
        check("mis_err",   {24'd0, bus.err_cnt}, 32'd3);
        tick();
        check("mis_idle_err", {24'd0, bus.err_cnt}, 32'd3);

        // Zero-length campaign clears counters and never drives stim
        bus.dut_y = 2'b10;
        run_camp(8'd0, 3'd1, -1, 20, done_at, unstable, inj_bad, zero_bad, load_err);
        check("zero_done_at", done_at, 32'd2);
        check("zero_load_err", {24'd0, load_err}, 32'd0);
        check("zero_stim", zero_bad, 32'd0);
        check("zero_err", {24'd0, bus.err_cnt}, 32'd0);
        tick();
        check("zero_pulse", {30'd0, bus.done, bus.busy}, 32'd0);

        // Start while busy with new site/length is ignored: LFSR A7,4E
        run_camp(8'd2, 3'd0, 5, 40, done_at, unstable, inj_bad, zero_bad, load_err);
        check("ign_done_at", done_at, 32'd10);
        check("ign_stim0", {26'd0, app_stim[0]}, 32'h26);
        check("ign_stim1", {26'd0, app_stim[1]}, 32'h0F);
        check("ign_inj",   inj_bad, 32'd0);
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra_done++;
        end
        check("ign_single_done", extra_done, 32'd0);
        check("ign_idx", {24'd0, bus.vec_idx}, 32'd1);

        // Reset during SETTLE of vector 5
        bus.dut_y       = 2'b01;
        bus.num_vectors = 8'd10;
        bus.fault_site  = 3'd0;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (22) tick();
        check("mid_idx",  {24'd0, bus.vec_idx}, 32'd5);
        check("mid_err",  {24'd0, bus.err_cnt}, 32'd5);
        check("mid_busy", {30'd0, bus.busy, bus.inj_en}, 32'd3);
        rstn = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy},    32'd0);
        check("arst_done", {31'd0, bus.done},    32'd0);
        check("arst_stim", {26'd0, bus.stim},    32'd0);
        check("arst_inj",  {31'd0, bus.inj_en},  32'd0);
        check("arst_err",  {24'd0, bus.err_cnt}, 32'd0);
        check("arst_idx",  {24'd0, bus.vec_idx}, 32'd0);
        bus.dut_y = 2'b10;
        @(negedge clk) rstn = 1'b1;
        tick();
        run_camp(8'd1, 3'd7, -1, 20, done_at, unstable, inj_bad, zero_bad, load_err);
        check("reseed_stim0", {26'd0, app_stim[0]}, 32'h25);
        check("reseed_done_at", done_at, 32'd6);
        tick();

        // Two back-to-back 255-vector campaigns with permanent mismatch
        bus.dut_y = 2'b01;
        run_camp(8'd255, 3'd3, -1, 1100, done_at, unstable, inj_bad, zero_bad, load_err);
        check("sat1_done_at", done_at, 32'd1022);
        check("sat1_err", {24'd0, bus.err_cnt}, 32'd255);
        check("sat1_inj", inj_bad, 32'd0);
        tick();
        check("sat1_idx", {24'd0, bus.vec_idx}, 32'd254);
        run_camp(8'd255, 3'd3, -1, 1100, done_at, unstable, inj_bad, zero_bad, load_err);
        check("sat2_load_err", {24'd0, load_err}, 32'd0);
        check("sat2_done_at", done_at, 32'd1022);
        check("sat2_err", {24'd0, bus.err_cnt}, 32'd255);
        tick();
        check("sat2_idle_err", {24'd0, bus.err_cnt}, 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
